// File: rtl/imem_load_arbiter_if.sv
// Bundle between the program loader, the CPU fetch path and InstructionMemory.
// The arbiter takes the slave side; whoever drives loader/fetch/reload takes the master side.
interface imem_load_arbiter_if;
  logic        ldValid;
  logic [7:0]  ldData;
  logic        ldLast;
  logic        ldReady;
  logic        reload;
  logic [31:0] fetchAddr;
  logic [31:0] memAddr;
  logic [7:0]  memWrData;
  logic        memWe;
  logic        memRw;
  logic        cpuHold;
  logic [7:0]  loadCount;
  logic        loadDone;
  logic        loadErr;

  modport master (
    output ldValid, ldData, ldLast, reload, fetchAddr,
    input  ldReady, memAddr, memWrData, memWe, memRw, cpuHold, loadCount, loadDone, loadErr
  );

  modport slave (
    input  ldValid, ldData, ldLast, reload, fetchAddr,
    output ldReady, memAddr, memWrData, memWe, memRw, cpuHold, loadCount, loadDone, loadErr
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares the InstructionMemory port: byte-serial program load with zero padding to a word
// boundary after reset or a reload, then a read passthrough of the CPU fetch address.
module imem_load_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          MAX_BYTES = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  imem_load_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LOAD, ALIGN, RUN} state_e;

  localparam logic [7:0] MaxCount = 8'(MAX_BYTES);

  state_e      state_q, state_d;
  logic [7:0]  loadCount_q, loadCount_d;
  logic        loadErr_q, loadErr_d;
  logic        memWe_q, memWe_d;
  logic [31:0] wrAddr_q, wrAddr_d;
  logic [7:0]  wrData_q, wrData_d;

  logic        countFull;
  logic        countAligned;
  logic [31:0] nextWrAddr;

  assign countFull    = (loadCount_q >= MaxCount);
  assign countAligned = (loadCount_q[1:0] == 2'b00);
  assign nextWrAddr   = BASE_ADDR + {24'd0, loadCount_q};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      loadCount_q <= 8'd0;
      loadErr_q   <= 1'b0;
      memWe_q     <= 1'b0;
      wrAddr_q    <= BASE_ADDR;
      wrData_q    <= 8'd0;
    end else begin
      state_q     <= state_d;
      loadCount_q <= loadCount_d;
      loadErr_q   <= loadErr_d;
      memWe_q     <= memWe_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
    end
  end

  // Every memory write is registered, so it appears the cycle after the byte or pad is decided.
  always_comb begin
    state_d     = state_q;
    loadCount_d = loadCount_q;
    loadErr_d   = loadErr_q;
    memWe_d     = 1'b0;
    wrAddr_d    = wrAddr_q;
    wrData_d    = wrData_q;
    unique case (state_q)
      IDLE: state_d = LOAD;
      LOAD: begin
        if (bus.ldValid) begin
          if (!countFull) begin
            memWe_d     = 1'b1;
            wrAddr_d    = nextWrAddr;
            wrData_d    = bus.ldData;
            loadCount_d = loadCount_q + 8'd1;
          end else begin
            loadErr_d = 1'b1;
          end
          if (bus.ldLast) state_d = ALIGN;
        end
      end
      ALIGN: begin
        if (!countAligned && !countFull) begin
          memWe_d     = 1'b1;
          wrAddr_d    = nextWrAddr;
          wrData_d    = 8'h00;
          loadCount_d = loadCount_q + 8'd1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // The write address returns to the base so the next load starts from a clean view.
        if (bus.reload) begin
          state_d     = LOAD;
          loadCount_d = 8'd0;
          loadErr_d   = 1'b0;
          wrAddr_d    = BASE_ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ldReady   = (state_q == LOAD);
  assign bus.cpuHold   = (state_q != RUN);
  assign bus.loadDone  = (state_q == RUN);
  assign bus.memRw     = (state_q == RUN);
  assign bus.memWe     = memWe_q;
  assign bus.memAddr   = (state_q == RUN) ? bus.fetchAddr : wrAddr_q;
  assign bus.memWrData = wrData_q;
  assign bus.loadCount = loadCount_q;
  assign bus.loadErr   = loadErr_q;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Self-checking bench: a load-sequence model checks every output each cycle, directed loads
// pin the model with literal expectations, and a random phase stresses reload/reset/overflow.
module tb_imem_load_arbiter;

  localparam logic [31:0] BASE = 32'd0;
  localparam int          MAXB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_load_arbiter_if bus ();

  imem_load_arbiter #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;
  bit checkEn     = 1'b0;

  // Model of a load session: boot delay, accepting bytes, pad phase, running.
  bit          mBoot      = 1'b0;
  bit          mAccepting = 1'b0;
  bit          mPadding   = 1'b0;
  bit          mRunning   = 1'b0;
  int          mPads      = 0;
  int          mCount     = 0;
  bit          mErr       = 1'b0;
  bit          mWe        = 1'b0;
  logic [31:0] mAddr      = 32'd0;
  logic [7:0]  mData      = 8'd0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mWe = 1'b0;
      if (rst) begin
        mBoot = 1'b1; mAccepting = 1'b0; mPadding = 1'b0; mRunning = 1'b0;
        mPads = 0; mCount = 0; mErr = 1'b0; mAddr = BASE; mData = 8'd0;
      end else if (mBoot) begin
        mBoot = 1'b0;
        mAccepting = 1'b1;
      end else if (mAccepting) begin
        if (bus.ldValid) begin
          if (mCount < MAXB) begin
            mWe = 1'b1; mAddr = BASE + 32'(mCount); mData = bus.ldData; mCount++;
          end else begin
            mErr = 1'b1;
          end
          if (bus.ldLast) begin
            mAccepting = 1'b0;
            mPadding = 1'b1;
            mPads = ((mCount % 4) == 0 || mCount >= MAXB) ? 0 : 4 - (mCount % 4);
          end
        end
      end else if (mPadding) begin
        if (mPads > 0) begin
          mWe = 1'b1; mAddr = BASE + 32'(mCount); mData = 8'h00; mCount++; mPads--;
        end else begin
          mPadding = 1'b0;
          mRunning = 1'b1;
        end
      end else if (mRunning && bus.reload) begin
        mRunning = 1'b0; mAccepting = 1'b1; mCount = 0; mErr = 1'b0; mAddr = BASE;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checkEn) begin
        checkOutput("ldReady",   32'(bus.ldReady),   32'(mAccepting));
        checkOutput("cpuHold",   32'(bus.cpuHold),   32'(!mRunning));
        checkOutput("loadDone",  32'(bus.loadDone),  32'(mRunning));
        checkOutput("memRw",     32'(bus.memRw),     32'(mRunning));
        checkOutput("memWe",     32'(bus.memWe),     32'(mWe));
        checkOutput("memAddr",   bus.memAddr,        mRunning ? bus.fetchAddr : mAddr);
        checkOutput("memWrData", 32'(bus.memWrData), 32'(mData));
        checkOutput("loadCount", 32'(bus.loadCount), 32'(mCount));
        checkOutput("loadErr",   32'(bus.loadErr),   32'(mErr));
        checkOutput("weRwExcl",  32'(bus.memWe & bus.memRw), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady();
    int k = 0;
    while (!bus.ldReady && k < 20) begin
      tick();
      k++;
    end
    checkOutput("waitReady", 32'(bus.ldReady), 32'd1);
  endtask

  task automatic waitRun();
    int k = 0;
    while (!bus.loadDone && k < 40) begin
      tick();
      k++;
    end
    checkOutput("waitRun", 32'(bus.loadDone), 32'd1);
  endtask

  task automatic doReload();
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
  endtask

  task automatic applyStimulus(input int n, input int gap, input logic [7:0] first, input bit withLast);
    for (int i = 0; i < n; i++) begin
      bus.ldValid = 1'b1;
      bus.ldData  = first + 8'(i);
      bus.ldLast  = withLast && (i == n - 1);
      tick();
      bus.ldValid = 1'b0;
      bus.ldLast  = 1'b0;
      repeat (gap) tick();
    end
  endtask

  initial begin
    bus.ldValid   = 1'b0;
    bus.ldData    = 8'd0;
    bus.ldLast    = 1'b0;
    bus.reload    = 1'b0;
    bus.fetchAddr = 32'd0;
    rst           = 1'b1;

    tick();
    checkEn = 1'b1;
    checkOutput("rst cpuHold",   32'(bus.cpuHold),   32'd1);
    checkOutput("rst ldReady",   32'(bus.ldReady),   32'd0);
    checkOutput("rst memWe",     32'(bus.memWe),     32'd0);
    checkOutput("rst memAddr",   bus.memAddr,        BASE);
    checkOutput("rst loadCount", 32'(bus.loadCount), 32'd0);
    rst = 1'b0;

    // Eight aligned bytes: last write lands in the single ALIGN cycle, then RUN.
    waitReady();
    applyStimulus(8, 0, 8'h01, 1'b1);
    checkOutput("t1 lastWe",   32'(bus.memWe),     32'd1);
    checkOutput("t1 lastAddr", bus.memAddr,        32'd7);
    checkOutput("t1 lastData", 32'(bus.memWrData), 32'h08);
    tick();
    checkOutput("t1 done",  32'(bus.loadDone),  32'd1);
    checkOutput("t1 hold",  32'(bus.cpuHold),   32'd0);
    checkOutput("t1 count", 32'(bus.loadCount), 32'd8);

    // Five bytes: three zero pads at 5,6,7 before RUN.
    doReload();
    checkOutput("t2 reloadCount", 32'(bus.loadCount), 32'd0);
    checkOutput("t2 reloadHold",  32'(bus.cpuHold),   32'd1);
    applyStimulus(5, 0, 8'h11, 1'b1);
    checkOutput("t2 lastAddr", bus.memAddr, 32'd4);
    for (int p = 5; p < 8; p++) begin
      tick();
      checkOutput("t2 padWe",   32'(bus.memWe),     32'd1);
      checkOutput("t2 padAddr", bus.memAddr,        32'(p));
      checkOutput("t2 padData", 32'(bus.memWrData), 32'h00);
      checkOutput("t2 padDone", 32'(bus.loadDone),  32'd0);
    end
    tick();
    checkOutput("t2 done",  32'(bus.loadDone),  32'd1);
    checkOutput("t2 count", 32'(bus.loadCount), 32'd8);

    // Fetch passthrough is combinational in RUN.
    for (int a = 0; a < 12; a += 4) begin
      bus.fetchAddr = 32'(a);
      #1;
      checkOutput("t3 fetchAddr", bus.memAddr,     32'(a));
      checkOutput("t3 memRw",     32'(bus.memRw),  32'd1);
      checkOutput("t3 memWe",     32'(bus.memWe),  32'd0);
    end

    // Overflow: ten bytes into an eight-byte memory.
    doReload();
    applyStimulus(10, 0, 8'h21, 1'b1);
    checkOutput("t4 noWrite", 32'(bus.memWe),     32'd0);
    checkOutput("t4 count",   32'(bus.loadCount), 32'd8);
    checkOutput("t4 err",     32'(bus.loadErr),   32'd1);
    waitRun();
    checkOutput("t4 errRun", 32'(bus.loadErr), 32'd1);
    doReload();
    checkOutput("t4 errClr",   32'(bus.loadErr),   32'd0);
    checkOutput("t4 countClr", 32'(bus.loadCount), 32'd0);

    // Gapped stream: address must hold during idle cycles.
    applyStimulus(4, 2, 8'h31, 1'b1);
    waitRun();
    checkOutput("t5 count", 32'(bus.loadCount), 32'd4);

    // Reset in the middle of a load cancels the pending write.
    doReload();
    applyStimulus(3, 0, 8'h41, 1'b0);
    checkOutput("t6 pendingWe", 32'(bus.memWe), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6 weCleared", 32'(bus.memWe),     32'd0);
    checkOutput("t6 hold",      32'(bus.cpuHold),   32'd1);
    checkOutput("t6 count",     32'(bus.loadCount), 32'd0);
    checkOutput("t6 addr",      bus.memAddr,        BASE);
    waitReady();
    applyStimulus(4, 0, 8'h51, 1'b1);
    checkOutput("t6 reloadAddr", bus.memAddr,        32'd3);
    checkOutput("t6 reloadData", 32'(bus.memWrData), 32'h54);
    waitRun();

    // Random traffic including stray LdLast, ignored reloads and occasional resets.
    for (int c = 0; c < 800; c++) begin
      bus.ldValid   = ($urandom_range(0, 9) < 6);
      bus.ldData    = 8'($urandom);
      bus.ldLast    = ($urandom_range(0, 7) == 0);
      bus.reload    = ($urandom_range(0, 11) == 0);
      bus.fetchAddr = $urandom;
      rst           = ($urandom_range(0, 149) == 0);
      tick();
    end
    bus.ldValid = 1'b0;
    bus.ldLast  = 1'b0;
    bus.reload  = 1'b0;
    rst         = 1'b0;
    tick();
    tick();

    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
